alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command-side initiator for the 32-bit ripple ALU. Accepts a decoded ALU command over valid/ready.
//  Drives the ALU's 4-bit control word and its operands, captures Result/Zero/Overflow, and returns
//  a registered response over valid/ready. Shift-left is executed iteratively as repeated ALU adds.
//  Sits between the decode stage and the ALU in the multicycle datapath.
// PARAMETERS
//  WIDTH   32  operand/result width; must equal ALU width
//  SHW     5   shamt width; log2(WIDTH)
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      asynchronous, active-high reset
//  req_valid     in   1      command valid
//  req_ready     out  1      sequencer idle, can accept
//  req_cmd       in   4      command: 0 AND,1 OR,2 NOR,3 ADD,4 ADDU,5 SUB,6 SUBU,7 SLT,8 SLL, 9-15 illegal
//  req_a         in   WIDTH  operand A (SLL: value shifted)
//  req_b         in   WIDTH  operand B (ignored for SLL)
//  req_shamt     in   SHW    shift amount (SLL only)
//  alu_a         out  WIDTH  ALU operand a
//  alu_b         out  WIDTH  ALU operand b
//  alu_ctrl      out  4      ALU control {Ainvert, Bnegate, Operation[1:0]}
//  alu_result    in   WIDTH  ALU Result (combinational, same cycle)
//  alu_zero      in   1      ALU Zero
//  alu_overflow  in   1      ALU Overflow
//  rsp_valid     out  1      response valid
//  rsp_ready     in   1      consumer accepts response
//  rsp_result    out  WIDTH  final result
//  rsp_zero      out  1      Zero of final ALU pass
//  rsp_trap      out  1      signed overflow on ADD/SUB only
//  rsp_illegal   out  1      req_cmd was 9-15
// BEHAVIOUR
//  - Control encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
//  - Reset: state IDLE. rsp_valid/rsp_result/rsp_zero/rsp_trap/rsp_illegal=0; alu_a/alu_b=0;
//    alu_ctrl=0000; req_ready=1.
//  - Reset mid-operation aborts the command; no response is produced.
//  - FSM states: IDLE, EXEC, SHIFT, RESP. req_ready=1 only in IDLE.
//  - IDLE: on req_valid, latch cmd/a/b/shamt.
//    - Legal non-SLL cmd -> EXEC.
//    - SLL -> SHIFT with count=shamt and acc=req_a.
//    - Illegal cmd -> RESP with result 0, zero 1, illegal 1, trap 0.
//  - EXEC (1 cycle): drive alu_a=A, alu_b=B, alu_ctrl=decode(cmd). Capture alu_result and alu_zero
//    into rsp_*. rsp_trap = alu_overflow & (cmd==ADD|SUB). Next state RESP.
//    - ADDU/SUBU use ADD/SUB encodings with trap suppressed. Result is written regardless of trap.
//  - SHIFT: each cycle drives alu_a=alu_b=acc with ADD and loads acc<=alu_result.
//    - count decrements; on count==1, capture into rsp_* and go to RESP.
//    - shamt==0: one pass with OR, alu_a=acc, alu_b=0; result=A.
//    - Overflow is ignored for SLL; rsp_trap=0.
//  - RESP: rsp_valid=1. All rsp_* held stable until rsp_ready; the handshake completes in a cycle
//    where both are high, then IDLE. rsp_valid drops the next cycle.
//    - No new request is accepted in the same cycle as the response handshake.
//  - In IDLE/RESP, alu_a/alu_b=0 and alu_ctrl=0000.
//  - Latency, accept edge = cycle 0:
//    - non-SLL: rsp_valid asserted from cycle 2.
//    - SLL: from cycle max(shamt,1)+1.
//    - illegal: from cycle 1.
//  - Width: all arithmetic modulo 2^WIDTH; acc is WIDTH bits; shifted-out bits lost.
// STRUCTURE
//  - Package alu_seq_pkg: cmd enum (CMD_AND..CMD_SLL), ALU control constants (ALUC_AND..ALUC_NOR),
//    FSM state typedef.
//  - Sub-module alu_cmd_decode (combinational): cmd -> {alu_ctrl, trap_en, legal}.
//  - The ALU is instantiated beside this block at datapath level, not inside it.
// TESTING
//  - ADD a=7 b=5 -> rsp_result=12, zero=0, trap=0, rsp_valid at cycle 2.
//  - ADD 0x7FFFFFFF+1 -> 0x80000000, trap=1. ADDU with the same operands -> same result, trap=0.
//  - SUB 9-9 -> result 0, zero=1. SLT a=0xFFFFFFFD(-3) b=2 -> result 1. NOR 0,0 -> 0xFFFFFFFF.
//  - SLL a=1 shamt=31 -> 0x80000000 at cycle 32, alu_ctrl=0010 for 31 cycles.
//    SLL a=0xA5 shamt=0 -> 0xA5 at cycle 2.
//  - Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0. req_valid held high -> accepted
//    only after the handshake.
//  - Assert reset during SLL shamt=20, cycle 8 -> all outputs at reset values, no rsp_valid.
//    cmd=12 -> illegal=1, result 0 at cycle 1.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU command sequencer: command codes, ALU control words, FSM states.
// Command numbering matches the decode stage; control words match the ripple ALU's {Ainv,Bneg,Op}.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        CMD_AND  = 4'd0,
        CMD_OR   = 4'd1,
        CMD_NOR  = 4'd2,
        CMD_ADD  = 4'd3,
        CMD_ADDU = 4'd4,
        CMD_SUB  = 4'd5,
        CMD_SUBU = 4'd6,
        CMD_SLT  = 4'd7,
        CMD_SLL  = 4'd8
    } cmd_e;

    localparam logic [3:0] ALUC_AND = 4'b0000;
    localparam logic [3:0] ALUC_OR  = 4'b0001;
    localparam logic [3:0] ALUC_ADD = 4'b0010;
    localparam logic [3:0] ALUC_SUB = 4'b0110;
    localparam logic [3:0] ALUC_SLT = 4'b0111;
    localparam logic [3:0] ALUC_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response bundle of the sequencer.
// master = sequencer side, slave = decode stage / ALU / consumer side.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_cmd;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [SHW-1:0]   req_shamt;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_overflow;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_trap;
    logic             rsp_illegal;

    modport master (
        input  req_valid, req_cmd, req_a, req_b, req_shamt,
        input  alu_result, alu_zero, alu_overflow, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_result, rsp_zero, rsp_trap, rsp_illegal
    );

    modport slave (
        output req_valid, req_cmd, req_a, req_b, req_shamt,
        output alu_result, alu_zero, alu_overflow, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_result, rsp_zero, rsp_trap, rsp_illegal
    );
endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Combinational command decode: ALU control word, signed-overflow trap enable, legality.
// SLL decodes to ADD; the sequencer handles the shift iteration itself.
module alu_cmd_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] cmd_i,
    output logic [3:0] alu_ctrl_o,
    output logic       trap_en_o,
    output logic       legal_o
);

    always_comb begin
        alu_ctrl_o = ALUC_AND;
        trap_en_o  = 1'b0;
        legal_o    = 1'b1;
        case (cmd_i)
            CMD_AND:  alu_ctrl_o = ALUC_AND;
            CMD_OR:   alu_ctrl_o = ALUC_OR;
            CMD_NOR:  alu_ctrl_o = ALUC_NOR;
            CMD_ADD:  begin alu_ctrl_o = ALUC_ADD; trap_en_o = 1'b1; end
            CMD_ADDU: alu_ctrl_o = ALUC_ADD;
            CMD_SUB:  begin alu_ctrl_o = ALUC_SUB; trap_en_o = 1'b1; end
            CMD_SUBU: alu_ctrl_o = ALUC_SUB;
            CMD_SLT:  alu_ctrl_o = ALUC_SLT;
            CMD_SLL:  alu_ctrl_o = ALUC_ADD;
            default:  legal_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one decoded command through the external ripple ALU and returns a registered response.
// Latency 2 (illegal 1, SLL max(shamt,1)+1); req_ready only when idle, response held until rsp_ready.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic clk,
    input  logic reset,
    alu_op_sequencer_if.master bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctrl_q;
    logic             trap_en_q;
    logic [SHW-1:0]   count_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_zero_q;
    logic             rsp_trap_q;
    logic             rsp_illegal_q;

    logic [3:0]       dec_ctrl;
    logic             dec_trap_en;
    logic             dec_legal;
    logic             shift_last;

    alu_cmd_decode u_decode (
        .cmd_i      (bus.req_cmd),
        .alu_ctrl_o (dec_ctrl),
        .trap_en_o  (dec_trap_en),
        .legal_o    (dec_legal)
    );

    // shamt==0 and the final doubling pass both finish the shift in this cycle
    assign shift_last = (count_q <= SHW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (!dec_legal)                 state_d = ST_RESP;
                    else if (bus.req_cmd == CMD_SLL) state_d = ST_SHIFT;
                    else                            state_d = ST_EXEC;
                end
            end
            ST_EXEC:  state_d = ST_RESP;
            ST_SHIFT: if (shift_last) state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_ctrl  = ALUC_AND;
        case (state_q)
            ST_EXEC: begin
                bus.alu_a    = a_q;
                bus.alu_b    = b_q;
                bus.alu_ctrl = ctrl_q;
            end
            ST_SHIFT: begin
                bus.alu_a = a_q;
                if (count_q == '0) begin
                    bus.alu_ctrl = ALUC_OR;
                end else begin
                    bus.alu_b    = a_q;
                    bus.alu_ctrl = ALUC_ADD;
                end
            end
            default: ;
        endcase
    end

    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_zero    = rsp_zero_q;
    assign bus.rsp_trap    = rsp_trap_q;
    assign bus.rsp_illegal = rsp_illegal_q;

    // a_q doubles as the shift accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q           <= '0;
            b_q           <= '0;
            ctrl_q        <= ALUC_AND;
            trap_en_q     <= 1'b0;
            count_q       <= '0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_trap_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        a_q       <= bus.req_a;
                        b_q       <= bus.req_b;
                        ctrl_q    <= dec_ctrl;
                        trap_en_q <= dec_trap_en;
                        count_q   <= bus.req_shamt;
                        if (!dec_legal) begin
                            rsp_result_q  <= '0;
                            rsp_zero_q    <= 1'b1;
                            rsp_trap_q    <= 1'b0;
                            rsp_illegal_q <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_result_q  <= bus.alu_result;
                    rsp_zero_q    <= bus.alu_zero;
                    rsp_trap_q    <= bus.alu_overflow & trap_en_q;
                    rsp_illegal_q <= 1'b0;
                end
                ST_SHIFT: begin
                    a_q     <= bus.alu_result;
                    count_q <= count_q - SHW'(1);
                    if (shift_last) begin
                        rsp_result_q  <= bus.alu_result;
                        rsp_zero_q    <= bus.alu_zero;
                        rsp_trap_q    <= 1'b0;
                        rsp_illegal_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: directed commands push hand-computed responses; a monitor pops and compares.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        trap;
        logic        ill;
        int          exp_edge;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   stall_next;
    exp_t sb[$];

    alu_op_sequencer_if #(.WIDTH(32), .SHW(5)) bus ();

    alu_op_sequencer #(.WIDTH(32), .SHW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ripple ALU standing beside the sequencer
    logic [31:0] alu_aa, alu_bb, alu_sum, alu_res;
    logic        alu_ovf;
    always_comb begin
        alu_aa  = bus.alu_ctrl[3] ? ~bus.alu_a : bus.alu_a;
        alu_bb  = bus.alu_ctrl[2] ? ~bus.alu_b : bus.alu_b;
        alu_sum = alu_aa + alu_bb + {31'b0, bus.alu_ctrl[2]};
        alu_ovf = (alu_aa[31] == alu_bb[31]) && (alu_sum[31] != alu_aa[31]);
        case (bus.alu_ctrl[1:0])
            2'b00:   alu_res = alu_aa & alu_bb;
            2'b01:   alu_res = alu_aa | alu_bb;
            2'b10:   alu_res = alu_sum;
            default: alu_res = {31'b0, alu_sum[31] ^ alu_ovf};
        endcase
        bus.alu_result   = alu_res;
        bus.alu_zero     = (alu_res == 32'd0);
        bus.alu_overflow = alu_ovf;
    end

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] res, input logic zero,
                        input logic trap, input logic ill, input int lat, input bit push,
                        output int acc_edge);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_cmd   = cmd;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_shamt = sh;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            errors++;
            checks++;
            $display("FAIL accept_timeout: cmd %0d never accepted", cmd);
        end
        acc_edge = cyc + 1;
        if (push) begin
            e.res = res; e.zero = zero; e.trap = trap; e.ill = ill;
            e.exp_edge = acc_edge + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.rsp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_timeout", {34'b0, sb.size() != 0}, 35'd0);
    endtask

    // Monitor: pops on each new response, then checks it stays frozen while stalled
    bit          in_rsp;
    int          stall;
    logic [34:0] snap;
    exp_t        got;
    initial begin
        bus.rsp_ready = 1'b1;
        in_rsp = 0;
        stall  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_rsp = 0;
            end else if (bus.rsp_valid) begin
                chk("req_ready_low_in_resp", {34'b0, bus.req_ready}, 35'd0);
                if (!in_rsp) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: result %h with empty scoreboard", bus.rsp_result);
                    end else begin
                        got = sb.pop_front();
                        chk("rsp_result", {3'b0, bus.rsp_result}, {3'b0, got.res});
                        chk("rsp_flags", {32'b0, bus.rsp_zero, bus.rsp_trap, bus.rsp_illegal},
                            {32'b0, got.zero, got.trap, got.ill});
                        chk("rsp_latency_edge", 35'(cyc + 1), 35'(got.exp_edge));
                    end
                    in_rsp     = 1;
                    snap       = {bus.rsp_result, bus.rsp_zero, bus.rsp_trap, bus.rsp_illegal};
                    stall      = stall_next;
                    stall_next = 0;
                end else begin
                    chk("rsp_stable", {bus.rsp_result, bus.rsp_zero, bus.rsp_trap, bus.rsp_illegal}, snap);
                end
                if (stall > 0) begin
                    bus.rsp_ready = 1'b0;
                    stall--;
                end else begin
                    bus.rsp_ready = 1'b1;
                    in_rsp = 0;
                end
            end
        end
    end

    initial begin
        int e0, e1, n, k;
        checks = 0; errors = 0; cyc = 0; stall_next = 0;
        bus.req_valid = 1'b0; bus.req_cmd = 4'd0;
        bus.req_a = '0; bus.req_b = '0; bus.req_shamt = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready_valid", {33'b0, bus.req_ready, bus.rsp_valid}, {33'b0, 2'b10});
        chk("reset_rsp", {bus.rsp_result, bus.rsp_zero, bus.rsp_trap, bus.rsp_illegal}, 35'd0);
        chk("reset_alu", {3'b0, bus.alu_a | bus.alu_b}, 35'd0);
        chk("reset_ctrl", {31'b0, bus.alu_ctrl}, 35'd0);
        reset = 1'b0;

        send(CMD_ADD,  32'd7,        32'd5,        5'd0, 32'd12,       1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_ADD,  32'h7FFFFFFF, 32'd1,        5'd0, 32'h80000000, 1'b0, 1'b1, 1'b0, 2, 1, e0);
        send(CMD_ADDU, 32'h7FFFFFFF, 32'd1,        5'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_SUB,  32'd9,        32'd9,        5'd0, 32'd0,        1'b1, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_SUB,  32'h80000000, 32'd1,        5'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 2, 1, e0);
        send(CMD_SUBU, 32'd0,        32'd1,        5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_SLT,  32'hFFFFFFFD, 32'd2,        5'd0, 32'd1,        1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_NOR,  32'd0,        32'd0,        5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_AND,  32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000F000, 1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_OR,   32'h0000F0F0, 32'h0000FF00, 5'd0, 32'h0000FFF0, 1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(4'd12,    32'd77,       32'd3,        5'd0, 32'd0,        1'b1, 1'b0, 1'b1, 1, 1, e0);
        send(4'd15,    32'd1,        32'd1,        5'd0, 32'd0,        1'b1, 1'b0, 1'b1, 1, 1, e0);
        send(CMD_SLL,  32'h000000A5, 32'hDEAD,     5'd0, 32'h000000A5, 1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_SLL,  32'd3,        32'd0,        5'd2, 32'd12,       1'b0, 1'b0, 1'b0, 3, 1, e0);
        send(CMD_SLL,  32'h80000001, 32'd0,        5'd1, 32'd2,        1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_SLL,  32'h80000000, 32'd0,        5'd1, 32'd0,        1'b1, 1'b0, 1'b0, 2, 1, e0);
        wait_idle();

        send(CMD_SLL, 32'd1, 32'd0, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 32, 1, e0);
        n = 0; k = 0;
        while (!bus.rsp_valid && k < 100) begin
            @(negedge clk);
            if (!bus.rsp_valid && bus.alu_ctrl == ALUC_ADD) n++;
            k++;
        end
        chk("sll31_add_cycles", 35'(n), 35'd31);
        wait_idle();

        // Stalled consumer: second command's valid stays high until the first handshake
        stall_next = 5;
        send(CMD_ADD, 32'd1,  32'd2,  5'd0, 32'd3,  1'b0, 1'b0, 1'b0, 2, 1, e0);
        send(CMD_OR,  32'h0F, 32'hF0, 5'd0, 32'hFF, 1'b0, 1'b0, 1'b0, 2, 1, e1);
        chk("hold_accept_edge", 35'(e1), 35'(e0 + 8));
        wait_idle();

        // Reset during a long shift: everything returns to reset values, no response appears
        send(CMD_SLL, 32'd1, 32'd0, 5'd20, 32'd0, 1'b0, 1'b0, 1'b0, 21, 0, e0);
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        chk("abort_ready_valid", {33'b0, bus.req_ready, bus.rsp_valid}, {33'b0, 2'b10});
        chk("abort_rsp", {bus.rsp_result, bus.rsp_zero, bus.rsp_trap, bus.rsp_illegal}, 35'd0);
        chk("abort_alu", {bus.alu_a | bus.alu_b, bus.alu_ctrl[2:0]}, 35'd0);
        chk("abort_ctrl3", {34'b0, bus.alu_ctrl[3]}, 35'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_rsp", {34'b0, bus.rsp_valid}, 35'd0);

        send(CMD_ADD, 32'd100, 32'd23, 5'd0, 32'd123, 1'b0, 1'b0, 1'b0, 2, 1, e0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
